audio_mix_interp: RTL and testbench

// Stereo N-source mixer feeding a CIC interpolator with a programmable stage count.
// - Captures NSRC signed stereo sources on an input-rate strobe.
// - Applies a per-source enable and a right-shift attenuation.
// - Mixes sequentially with one adder per channel, then saturates to IW bits.
// - Upsamples by RATE into the output-rate domain.

---
 rtl/audio_mix_interp.sv | 229 ++++++++++++++++++++++
 tb/tb_audio_mix_interp.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_interp.sv
`default_nettype none
// ============================================================================
// Module   : audio_mix_interp
// Summary  : Stereo N-source attenuating mixer with saturation, feeding a
//            per-channel CIC interpolator (zero-stuffed, unity DC gain).
// Revision : 1.0
// ============================================================================
module audio_mix_interp #(
    parameter int IW     = 16,
    parameter int NSRC   = 4,
    parameter int GW     = 4,
    parameter int STAGES = 2,
    parameter int RATE   = 4,
    parameter int CALCW  = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cen_in,
    input  logic                 cen_out,
    input  logic [NSRC*IW-1:0]   src_l,
    input  logic [NSRC*IW-1:0]   src_r,
    input  logic [NSRC-1:0]      src_mask,
    input  logic [NSRC*GW-1:0]   src_shift,
    input  logic                 clip_clr,
    output logic [IW-1:0]        snd_l_out,
    output logic [IW-1:0]        snd_r_out,
    output logic                 clip,
    output logic                 ovr
);

    localparam int c_KW  = $clog2(NSRC);
    localparam int c_AW  = IW + c_KW;
    localparam int c_OSH = (STAGES - 1) * $clog2(RATE);

    localparam logic [c_KW-1:0]         c_KLAST = c_KW'(NSRC - 1);
    localparam logic signed [c_AW-1:0]  c_AMAX  = c_AW'({1'b0, {(IW-1){1'b1}}});
    localparam logic signed [c_AW-1:0]  c_AMIN  = ~c_AMAX;
    localparam logic signed [CALCW-1:0] c_OMAX  = CALCW'({1'b0, {(IW-1){1'b1}}});
    localparam logic signed [CALCW-1:0] c_OMIN  = ~c_OMAX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_SAT  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_KW-1:0]         r_k;
    logic [NSRC*IW-1:0]      r_hold_l;
    logic [NSRC*IW-1:0]      r_hold_r;
    logic [NSRC-1:0]         r_mask;
    logic [NSRC*GW-1:0]      r_shift;
    logic signed [c_AW-1:0]  r_acc_l;
    logic signed [c_AW-1:0]  r_acc_r;
    logic signed [IW-1:0]    r_mix_l;
    logic signed [IW-1:0]    r_mix_r;
    logic                    r_mix_vld;
    logic                    r_clip;
    logic                    r_ovr;
    logic                    r_cout_d;

    logic [GW-1:0]           w_sh;
    logic signed [IW-1:0]    w_shl_l;
    logic signed [IW-1:0]    w_shl_r;
    logic signed [c_AW-1:0]  w_ext_l;
    logic signed [c_AW-1:0]  w_ext_r;
    logic                    w_hi_l;
    logic                    w_lo_l;
    logic                    w_hi_r;
    logic                    w_lo_r;
    logic signed [IW-1:0]    w_sat_l;
    logic signed [IW-1:0]    w_sat_r;

    // Current source term (selected by k) and the clamp of the finished sums.
    always_comb begin
        w_sh    = r_shift[r_k*GW +: GW];
        w_shl_l = $signed(r_hold_l[r_k*IW +: IW]) >>> w_sh;
        w_shl_r = $signed(r_hold_r[r_k*IW +: IW]) >>> w_sh;
        w_ext_l = {{c_KW{w_shl_l[IW-1]}}, w_shl_l};
        w_ext_r = {{c_KW{w_shl_r[IW-1]}}, w_shl_r};
        w_hi_l  = r_acc_l > c_AMAX;
        w_lo_l  = r_acc_l < c_AMIN;
        w_hi_r  = r_acc_r > c_AMAX;
        w_lo_r  = r_acc_r < c_AMIN;
        w_sat_l = w_hi_l ? c_AMAX[IW-1:0] : (w_lo_l ? c_AMIN[IW-1:0] : r_acc_l[IW-1:0]);
        w_sat_r = w_hi_r ? c_AMAX[IW-1:0] : (w_lo_r ? c_AMIN[IW-1:0] : r_acc_r[IW-1:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_hold_l  <= '0;
            r_hold_r  <= '0;
            r_mask    <= '0;
            r_shift   <= '0;
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_mix_l   <= '0;
            r_mix_r   <= '0;
            r_mix_vld <= 1'b0;
            r_clip    <= 1'b0;
            r_ovr     <= 1'b0;
            r_cout_d  <= 1'b0;
        end else begin
            r_mix_vld <= 1'b0;
            r_cout_d  <= cen_out;
            case (r_state)
                S_IDLE: begin
                    if (cen_in) begin
                        r_hold_l <= src_l;
                        r_hold_r <= src_r;
                        r_mask   <= src_mask;
                        r_shift  <= src_shift;
                        r_acc_l  <= '0;
                        r_acc_r  <= '0;
                        r_k      <= '0;
                        r_state  <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (r_mask[r_k]) begin
                        r_acc_l <= r_acc_l + w_ext_l;
                        r_acc_r <= r_acc_r + w_ext_r;
                    end
                    if (r_k == c_KLAST) begin
                        r_k     <= '0;
                        r_state <= S_SAT;
                    end else begin
                        r_k <= r_k + c_KW'(1);
                    end
                    if (cen_in) r_ovr <= 1'b1;
                end
                S_SAT: begin
                    r_mix_l   <= w_sat_l;
                    r_mix_r   <= w_sat_r;
                    r_mix_vld <= 1'b1;
                    r_state   <= S_IDLE;
                    if (cen_in) r_ovr <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
            // A clamp in the same clock as a clear keeps the flag set.
            if (r_state == S_SAT && (w_hi_l || w_lo_l || w_hi_r || w_lo_r)) begin
                r_clip <= 1'b1;
            end else if (clip_clr) begin
                r_clip <= 1'b0;
            end
        end
    end

    logic signed [IW-1:0] w_mix [2];
    logic [IW-1:0]        w_out [2];

    assign w_mix[0] = r_mix_l;
    assign w_mix[1] = r_mix_r;

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic signed [CALCW-1:0] r_dly  [STAGES];
        logic signed [CALCW-1:0] r_int  [STAGES];
        logic signed [CALCW-1:0] r_pend;
        logic                    r_fresh;
        logic [IW-1:0]           r_out;
        logic signed [CALCW-1:0] w_cmb  [STAGES+1];
        logic signed [CALCW-1:0] w_isum [STAGES+1];
        logic signed [CALCW-1:0] w_ish;
        logic signed [IW-1:0]    w_osat;

        // Comb chain runs at the mix rate; integrators see the pending comb
        // result once, then zeros until the next mix sample arrives.
        always_comb begin
            w_cmb[0] = {{(CALCW-IW){w_mix[ch][IW-1]}}, w_mix[ch]};
            for (int s = 0; s < STAGES; s++) begin
                w_cmb[s+1] = w_cmb[s] - r_dly[s];
            end
            w_isum[0] = r_fresh ? r_pend : '0;
            for (int s = 0; s < STAGES; s++) begin
                w_isum[s+1] = r_int[s] + w_isum[s];
            end
            w_ish = r_int[STAGES-1] >>> c_OSH;
            if (w_ish > c_OMAX) begin
                w_osat = c_OMAX[IW-1:0];
            end else if (w_ish < c_OMIN) begin
                w_osat = c_OMIN[IW-1:0];
            end else begin
                w_osat = w_ish[IW-1:0];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 0; s < STAGES; s++) begin
                    r_dly[s] <= '0;
                    r_int[s] <= '0;
                end
                r_pend  <= '0;
                r_fresh <= 1'b0;
                r_out   <= '0;
            end else begin
                if (r_mix_vld) begin
                    for (int s = 0; s < STAGES; s++) begin
                        r_dly[s] <= w_cmb[s];
                    end
                    r_pend  <= w_cmb[STAGES];
                    r_fresh <= 1'b1;
                end else if (cen_out) begin
                    r_fresh <= 1'b0;
                end
                if (cen_out) begin
                    for (int s = 0; s < STAGES; s++) begin
                        r_int[s] <= w_isum[s+1];
                    end
                end
                if (r_cout_d) begin
                    r_out <= w_osat;
                end
            end
        end

        assign w_out[ch] = r_out;
    end

    assign snd_l_out = w_out[0];
    assign snd_r_out = w_out[1];
    assign clip      = r_clip;
    assign ovr       = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_audio_mix_interp.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_mix_interp
// Summary  : Directed bench for audio_mix_interp with a queue scoreboard fed
//            by an FIR-equivalent model of the mixer plus 2-stage, x4 CIC.
// Revision : 1.0
// ============================================================================
module tb_audio_mix_interp;

    localparam int IW     = 16;
    localparam int NSRC   = 4;
    localparam int GW     = 4;
    localparam int STAGES = 2;
    localparam int RATE   = 4;
    localparam int CALCW  = 24;

    logic                 clk      = 1'b0;
    logic                 reset    = 1'b0;
    logic                 cen_in   = 1'b0;
    logic                 cen_out  = 1'b0;
    logic                 clip_clr = 1'b0;
    logic [NSRC*IW-1:0]   src_l    = '0;
    logic [NSRC*IW-1:0]   src_r    = '0;
    logic [NSRC-1:0]      src_mask = '0;
    logic [NSRC*GW-1:0]   src_shift = '0;
    logic [IW-1:0]        snd_l_out;
    logic [IW-1:0]        snd_r_out;
    logic                 clip;
    logic                 ovr;

    logic co_d  = 1'b0;
    logic co_d2 = 1'b0;
    int   ncomp = 0;
    int   nfail = 0;
    int   q_l[$];
    int   q_r[$];
    int   prev_l = 0;
    int   prev_r = 0;

    audio_mix_interp #(
        .IW(IW), .NSRC(NSRC), .GW(GW), .STAGES(STAGES), .RATE(RATE), .CALCW(CALCW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cen_in(cen_in),
        .cen_out(cen_out),
        .src_l(src_l),
        .src_r(src_r),
        .src_mask(src_mask),
        .src_shift(src_shift),
        .clip_clr(clip_clr),
        .snd_l_out(snd_l_out),
        .snd_r_out(snd_r_out),
        .clip(clip),
        .ovr(ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        co_d  <= cen_out;
        co_d2 <= co_d;
    end

    task automatic check(input string tag, input int obs, input int exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp16(input int x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int mixv(input logic [63:0] s, input logic [3:0] mk, input logic [15:0] sh);
        int acc;
        int v;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            if (mk[k]) begin
                v = $signed(s[k*16 +: 16]);
                acc += v >>> sh[k*4 +: 4];
            end
        end
        return clamp16(acc);
    endfunction

    // 2-stage CIC with x4 zero-stuffing equals a triangular FIR 1,2,3,4,3,2,1
    // followed by a divide-by-4.
    function automatic int outv(input int m, input int pv, input int p);
        int h[8];
        int y;
        h = '{1, 2, 3, 4, 3, 2, 1, 0};
        y = (m * h[p] + pv * h[p+4]) >>> 2;
        return clamp16(y);
    endfunction

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        logic [63:0] r;
        r[15:0]  = a[15:0];
        r[31:16] = b[15:0];
        r[47:32] = c[15:0];
        r[63:48] = d[15:0];
        return r;
    endfunction

    function automatic logic [15:0] pack_sh(input int a, input int b, input int c, input int d);
        logic [15:0] r;
        r[3:0]   = a[3:0];
        r[7:4]   = b[3:0];
        r[11:8]  = c[3:0];
        r[15:12] = d[3:0];
        return r;
    endfunction

    task automatic idle(input int n, input bit clr);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cen_in   = 1'b0;
            cen_out  = 1'b0;
            clip_clr = clr;
        end
    endtask

    task automatic do_reset();
        idle(1, 1'b0);
        reset = 1'b1;
        idle(2, 1'b0);
        reset  = 1'b0;
        prev_l = 0;
        prev_r = 0;
    endtask

    // One input-rate period: cen_in at cycle 0, cen_out at cycles 7,15,23,31.
    task automatic frame(input logic [63:0] sl, input logic [63:0] sr, input logic [3:0] mk,
                         input logic [15:0] sh, input int ovr_at, input int clr_at);
        int ml;
        int mr;
        ml = mixv(sl, mk, sh);
        mr = mixv(sr, mk, sh);
        for (int p = 0; p < 4; p++) begin
            q_l.push_back(outv(ml, prev_l, p));
            q_r.push_back(outv(mr, prev_r, p));
        end
        prev_l = ml;
        prev_r = mr;
        for (int j = 0; j < 32; j++) begin
            @(posedge clk); #1;
            cen_in   = (j == 0) || (j == ovr_at);
            cen_out  = (j % 8 == 7);
            clip_clr = (j == clr_at);
            if (j == 0) begin
                src_l = sl; src_r = sr; src_mask = mk; src_shift = sh;
            end
            if (j == ovr_at) begin
                src_l = ~sl; src_r = ~sr; src_mask = '1; src_shift = '0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (co_d2) begin
            check("sb_pending", int'(q_l.size() > 0), 1);
            if (q_l.size() > 0) begin
                check("out_l", $signed(snd_l_out), q_l.pop_front());
                check("out_r", $signed(snd_r_out), q_r.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle(2, 1'b0);
        reset = 1'b0;
        idle(1, 1'b0);
        check("rst_l", $signed(snd_l_out), 0);
        check("rst_r", $signed(snd_r_out), 0);
        check("rst_clip", clip, 0);
        check("rst_ovr", ovr, 0);

        repeat (6) frame(pack4(1000, 0, 0, 0), pack4(1000, 0, 0, 0), 4'b0001, 16'h0000, -1, -1);
        idle(3, 1'b0);
        check("dc_l", $signed(snd_l_out), 1000);
        check("dc_r", $signed(snd_r_out), 1000);

        do_reset();
        frame(pack4(4096, 0, 0, 0), pack4(-4096, 0, 0, 0), 4'b0001, 16'h0000, -1, -1);
        repeat (3) frame(pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), 4'b0001, 16'h0000, -1, -1);
        idle(3, 1'b0);
        check("imp_tail_l", $signed(snd_l_out), 0);

        do_reset();
        repeat (4) frame(pack4(0, -8192, 5000, 0), pack4(0, 3001, 5000, 0), 4'b0010,
                         pack_sh(0, 2, 0, 0), -1, -1);
        idle(3, 1'b0);
        check("atten_l", $signed(snd_l_out), -2048);
        check("atten_r", $signed(snd_r_out), 750);

        do_reset();
        check("ovr_pre", ovr, 0);
        frame(pack4(300, 0, 0, 0), pack4(-300, 0, 0, 0), 4'b0001, 16'h0000, 3, -1);
        check("ovr_set", ovr, 1);
        frame(pack4(300, 0, 0, 0), pack4(-300, 0, 0, 0), 4'b0001, 16'h0000, -1, -1);
        check("ovr_sticky", ovr, 1);
        check("ovr_noclip", clip, 0);

        frame(pack4(28672, 28672, 28672, 28672), pack4(-28672, -28672, -28672, -28672),
              4'b1111, 16'h0000, -1, -1);
        check("clip_set", clip, 1);
        idle(1, 1'b1);
        idle(1, 1'b0);
        check("clip_clr", clip, 0);
        frame(pack4(28672, 28672, 28672, 28672), pack4(-28672, -28672, -28672, -28672),
              4'b1111, 16'h0000, -1, 5);
        check("clip_coinc", clip, 1);
        idle(3, 1'b0);
        check("sat_l", $signed(snd_l_out), 32767);
        check("sat_r", $signed(snd_r_out), -32768);

        // Abandon a mix with k=2 in flight.
        @(posedge clk); #1;
        src_l = pack4(28672, 28672, 28672, 28672);
        src_r = pack4(-28672, -28672, -28672, -28672);
        src_mask = 4'b1111;
        cen_in = 1'b1;
        @(posedge clk); #1;
        cen_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("mid_l", $signed(snd_l_out), 0);
        check("mid_r", $signed(snd_r_out), 0);
        check("mid_clip", clip, 0);
        check("mid_ovr", ovr, 0);
        idle(2, 1'b0);
        reset  = 1'b0;
        prev_l = 0;
        prev_r = 0;

        repeat (3) frame(pack4(1234, 0, 0, 0), pack4(0, -777, 0, 0), 4'b0011, 16'h0000, -1, -1);
        idle(3, 1'b0);
        check("post_l", $signed(snd_l_out), 1234);
        check("post_r", $signed(snd_r_out), -777);
        check("post_clip", clip, 0);
        check("sb_drain", q_l.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
